// File: rtl/alu_result_queue_pkg.sv
// Shared ALU definitions: command codes and the packed layout of a queued result entry.
// The ALU and the result queue both import this package.
package alu_result_queue_pkg;

    typedef logic [2:0] alu_cmd_t;

    localparam alu_cmd_t ADD_  = 3'd0;
    localparam alu_cmd_t SUB_  = 3'd1;
    localparam alu_cmd_t XOR_  = 3'd2;
    localparam alu_cmd_t SLT_  = 3'd3;
    localparam alu_cmd_t AND_  = 3'd4;
    localparam alu_cmd_t NAND_ = 3'd5;
    localparam alu_cmd_t NOR_  = 3'd6;
    localparam alu_cmd_t OR_   = 3'd7;

    // Entry layout: {command[2:0], overflow, zero, carryout, result[31:0]}
    localparam int RESULT_W   = 32;
    localparam int RESULT_LSB = 0;
    localparam int CARRY_BIT  = 32;
    localparam int ZERO_BIT   = 33;
    localparam int OVF_BIT    = 34;
    localparam int CMD_W      = 3;
    localparam int CMD_LSB    = 35;
    localparam int ENTRY_W    = 38;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [RESULT_W-1:0] result,
        input logic                carryout,
        input logic                zero,
        input logic                overflow,
        input alu_cmd_t            command
    );
        return {command, overflow, zero, carryout, result};
    endfunction

    // Only arithmetic commands make the overflow flag meaningful for the sticky status.
    function automatic logic is_arith(input alu_cmd_t command);
        return (command == ADD_) || (command == SUB_);
    endfunction

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer-side and consumer-side handshake of the ALU result queue.
// The queue uses the slave modport; the ALU/consumer environment uses master.
interface alu_result_queue_if;
    import alu_result_queue_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_result;
    logic          in_carryout;
    logic          in_zero;
    logic          in_overflow;
    alu_cmd_t      in_command;

    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_result;
    logic          out_carryout;
    logic          out_zero;
    logic          out_overflow;
    alu_cmd_t      out_command;

    modport master (
        output in_valid, in_result, in_carryout, in_zero, in_overflow, in_command,
        input  in_ready,
        output out_ready,
        input  out_valid, out_result, out_carryout, out_zero, out_overflow, out_command
    );

    modport slave (
        input  in_valid, in_result, in_carryout, in_zero, in_overflow, in_command,
        output in_ready,
        input  out_ready,
        output out_valid, out_result, out_carryout, out_zero, out_overflow, out_command
    );

endinterface

// File: rtl/alu_result_queue_result_fifo_mem.sv
// DEPTH x W storage for queued entries: one synchronous write port, one asynchronous read port.
module result_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 38
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_queue.sv
// Queue of ALU results and flags with a sticky arithmetic-overflow bit and a saturating
// count of accepted operations. Head data is read combinationally and forced to 0 when empty.
module alu_result_queue
    import alu_result_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_result_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sticky_ovf,
    input  logic                     clr_sticky,
    output logic [CNT_W-1:0]         op_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_ptr_reg;
    logic [AW:0]          rd_ptr_reg;
    logic                 sticky_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   wr_entry;
    logic [ENTRY_W-1:0]   rd_entry;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;

    assign wr_entry = pack_entry(bus.in_result, bus.in_carryout, bus.in_zero,
                                 bus.in_overflow, bus.in_command);

    result_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            sticky_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // A qualifying overflow on the same edge as a clear keeps the bit set.
            if (push && bus.in_overflow && is_arith(bus.in_command)) begin
                sticky_reg <= 1'b1;
            end else if (clr_sticky) begin
                sticky_reg <= 1'b0;
            end
            if (push && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign bus.in_ready     = !full;
    assign bus.out_valid    = !empty;
    assign bus.out_result   = empty ? '0   : rd_entry[RESULT_LSB +: RESULT_W];
    assign bus.out_carryout = empty ? 1'b0 : rd_entry[CARRY_BIT];
    assign bus.out_zero     = empty ? 1'b0 : rd_entry[ZERO_BIT];
    assign bus.out_overflow = empty ? 1'b0 : rd_entry[OVF_BIT];
    assign bus.out_command  = empty ? '0   : rd_entry[CMD_LSB +: CMD_W];

    assign level      = wr_ptr_reg - rd_ptr_reg;
    assign sticky_ovf = sticky_reg;
    assign op_count   = count_reg;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed plus randomized bench for alu_result_queue against a queue-based reference model;
// a second instance with a 4-bit counter covers op_count saturation.
module tb_alu_result_queue;
    import alu_result_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             clr_sticky;
    logic [LW-1:0]    level;
    logic             sticky_ovf;
    logic [CNT_W-1:0] op_count;

    logic             clr_sticky2;
    logic [LW-1:0]    level2;
    logic             sticky_ovf2;
    logic [3:0]       op_count2;

    alu_result_queue_if qif ();
    alu_result_queue_if qif2 ();

    alu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (qif.slave),
        .level      (level),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky),
        .op_count   (op_count)
    );

    alu_result_queue #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (qif2.slave),
        .level      (level2),
        .sticky_ovf (sticky_ovf2),
        .clr_sticky (clr_sticky2),
        .op_count   (op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: contents in order, plus sticky bit and counters.
    logic [37:0] mq [$];
    bit          m_sticky;
    int          m_count;
    int          m_count2;
    int          m_n2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sticky = 1'b0;
        m_count  = 0;
        m_count2 = 0;
        m_n2     = 0;
    endtask

    task automatic set_in(input bit v, input logic [31:0] r, input alu_cmd_t c,
                          input bit ovf, input bit z, input bit co);
        qif.in_valid    = v;
        qif.in_result   = r;
        qif.in_command  = c;
        qif.in_overflow = ovf;
        qif.in_zero     = z;
        qif.in_carryout = co;
    endtask

    // One clock: predict acceptance from pre-edge state, advance the model, settle 1 ns.
    task automatic cycle();
        bit          push, pop, push2, pop2;
        logic [37:0] e;
        push  = qif.in_valid && (mq.size() < DEPTH);
        pop   = qif.out_ready && (mq.size() > 0);
        e     = {qif.in_command, qif.in_overflow, qif.in_zero, qif.in_carryout, qif.in_result};
        push2 = qif2.in_valid && (m_n2 < DEPTH);
        pop2  = qif2.out_ready && (m_n2 > 0);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        if (push && qif.in_overflow && (qif.in_command == ADD_ || qif.in_command == SUB_))
            m_sticky = 1'b1;
        else if (clr_sticky)
            m_sticky = 1'b0;
        if (push && m_count < (1 << CNT_W) - 1) m_count++;
        if (push2 && m_count2 < 15) m_count2++;
        m_n2 = m_n2 + (push2 ? 1 : 0) - (pop2 ? 1 : 0);
        #1;
    endtask

    task automatic check_all(input string ph);
        logic [37:0] h;
        h = (mq.size() > 0) ? mq[0] : 38'd0;
        chk({ph, ":in_ready"},  64'(qif.in_ready),     64'(mq.size() < DEPTH));
        chk({ph, ":out_valid"}, 64'(qif.out_valid),    64'(mq.size() > 0));
        chk({ph, ":level"},     64'(level),            64'(mq.size()));
        chk({ph, ":result"},    64'(qif.out_result),   64'(h[31:0]));
        chk({ph, ":carry"},     64'(qif.out_carryout), 64'(h[32]));
        chk({ph, ":zero"},      64'(qif.out_zero),     64'(h[33]));
        chk({ph, ":ovf"},       64'(qif.out_overflow), 64'(h[34]));
        chk({ph, ":command"},   64'(qif.out_command),  64'(h[37:35]));
        chk({ph, ":sticky"},    64'(sticky_ovf),       64'(m_sticky));
        chk({ph, ":op_count"},  64'(op_count),         64'(m_count));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        clr_sticky  = 1'b0;
        clr_sticky2 = 1'b0;
        set_in(1'b0, 32'd0, ADD_, 1'b0, 1'b0, 1'b0);
        qif.out_ready     = 1'b0;
        qif2.in_valid     = 1'b0;
        qif2.in_result    = 32'd0;
        qif2.in_command   = ADD_;
        qif2.in_overflow  = 1'b0;
        qif2.in_zero      = 1'b0;
        qif2.in_carryout  = 1'b0;
        qif2.out_ready    = 1'b1;
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_in_ready", 64'(qif.in_ready), 64'd1);
        chk("rst_out_valid", 64'(qif.out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_sticky", 64'(sticky_ovf), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_out_result", 64'(qif.out_result), 64'd0);

        // Single entry, one-cycle latency
        set_in(1'b1, 32'd42, ADD_, 1'b0, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, 32'd0, ADD_, 1'b0, 1'b0, 1'b0);
        chk("single_valid", 64'(qif.out_valid), 64'd1);
        chk("single_result", 64'(qif.out_result), 64'd42);
        chk("single_level", 64'(level), 64'd1);
        check_all("single");
        qif.out_ready = 1'b1;
        cycle();
        qif.out_ready = 1'b0;
        check_all("single_pop");

        // Fill with out_ready low, then attempt a fifth push
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 32'(i), XOR_, 1'b0, 1'b0, 1'b0);
            cycle();
            check_all("fill");
        end
        chk("full_in_ready", 64'(qif.in_ready), 64'd0);
        chk("full_level", 64'(level), 64'd4);
        set_in(1'b1, 32'd5, XOR_, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("full_reject_level", 64'(level), 64'd4);
        chk("full_reject_head", 64'(qif.out_result), 64'd1);
        check_all("full_reject");
        set_in(1'b0, 32'd0, ADD_, 1'b0, 1'b0, 1'b0);

        // Drain in order
        qif.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_head", 64'(qif.out_result), 64'(i));
            cycle();
            check_all("drain");
        end
        chk("drain_empty", 64'(qif.out_valid), 64'd0);

        // Sticky overflow rules (out_ready stays high so the queue never fills)
        set_in(1'b1, 32'h7FFF_FFFF, ADD_, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("sticky_add", 64'(sticky_ovf), 64'd1);
        set_in(1'b0, 32'd0, ADD_, 1'b0, 1'b0, 1'b0);
        clr_sticky = 1'b1;
        cycle();
        clr_sticky = 1'b0;
        chk("sticky_clr", 64'(sticky_ovf), 64'd0);
        set_in(1'b1, 32'd7, XOR_, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("sticky_xor", 64'(sticky_ovf), 64'd0);
        check_all("sticky_xor");
        set_in(1'b1, 32'h8000_0000, SUB_, 1'b1, 1'b0, 1'b1);
        clr_sticky = 1'b1;
        cycle();
        clr_sticky = 1'b0;
        set_in(1'b0, 32'd0, ADD_, 1'b0, 1'b0, 1'b0);
        chk("sticky_sub_clr", 64'(sticky_ovf), 64'd1);
        check_all("sticky_sub_clr");
        cycle();

        // Reset in the middle of operation
        do_reset();
        qif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(100 + i), SUB_, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b0, 32'd0, ADD_, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", 64'(level), 64'd3);
        chk("pre_rst_count", 64'(op_count), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(qif.out_valid), 64'd0);
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_op_count", 64'(op_count), 64'd0);
        chk("midrst_sticky", 64'(sticky_ovf), 64'd0);
        chk("midrst_out_result", 64'(qif.out_result), 64'd0);
        chk("midrst_in_ready", 64'(qif.in_ready), 64'd1);
        model_reset();
        #1;
        rst_n = 1'b1;
        #1;

        // Streaming across the pointer wrap
        qif.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'(200 + i), alu_cmd_t'(i % 8), 1'b0, 1'(i % 2), 1'(i % 3 == 0));
            cycle();
            chk("stream_level", 64'(level), 64'd1);
            chk("stream_head", 64'(qif.out_result), 64'(200 + i));
            check_all("stream");
        end
        set_in(1'b0, 32'd0, ADD_, 1'b0, 1'b0, 1'b0);
        chk("stream_op_count", 64'(op_count), 64'd10);
        cycle();
        check_all("stream_end");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), $urandom(), alu_cmd_t'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            qif.out_ready = 1'($urandom_range(0, 2) != 0);
            clr_sticky    = 1'($urandom_range(0, 9) == 0);
            cycle();
            check_all("rand");
        end
        set_in(1'b0, 32'd0, ADD_, 1'b0, 1'b0, 1'b0);
        clr_sticky = 1'b0;

        // Saturating counter on the 4-bit instance
        qif2.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            qif2.in_valid  = 1'b1;
            qif2.in_result = $urandom();
            cycle();
            chk("sat_op_count", 64'(op_count2), 64'(m_count2));
            chk("sat_level", 64'(level2), 64'(m_n2));
            chk("sat_sticky", 64'(sticky_ovf2), 64'd0);
        end
        qif2.in_valid = 1'b0;
        chk("sat_hold", 64'(op_count2), 64'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
